// File: rtl/rgb_pwm_pkg.sv
// Shared types and the triangle-fade step helper for the RGB PWM sequencer.
package rgb_pwm_pkg;

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      PAUSE      = 2'd1,
      PAUSE_HELD = 2'd2
   } mode_t;

   // Widest level the helper supports; callers zero-extend narrower levels.
   localparam int LVL_W = 16;

   // Returns {down_next, lvl_next}. The sum is one bit wider so it never wraps.
   function automatic logic [LVL_W:0] fade_step(
      input logic [LVL_W-1:0] lvl,
      input logic             down,
      input logic [LVL_W-1:0] step,
      input logic [LVL_W-1:0] max
   );
      logic [LVL_W:0] sum;
      sum = {1'b0, lvl} + {1'b0, step};
      if (!down) begin
         if (sum >= {1'b0, max}) return {1'b1, max};
         return {1'b0, sum[LVL_W-1:0]};
      end
      if (lvl <= step) return {1'b0, {LVL_W{1'b0}}};
      return {1'b1, lvl - step};
   endfunction

endpackage

// File: rtl/rgb_pwm_seq_if.sv
// Board-side signals of the sequencer: button in, PWM/mode/level status out.
interface rgb_pwm_seq_if #(
   parameter int CHANNELS = 3,
   parameter int PWM_BITS = 8
) ();
   logic                         btn;
   logic [CHANNELS-1:0]          pwm_o;
   logic [1:0]                   mode_o;
   logic                         advance_o;
   logic [CHANNELS*PWM_BITS-1:0] lvl_o;

   modport master (output btn, input pwm_o, mode_o, advance_o, lvl_o);
   modport slave  (input btn, output pwm_o, mode_o, advance_o, lvl_o);
endinterface

// File: rtl/btn_debounce.sv
// Button synchroniser and debouncer producing one-cycle press/release pulses.
module btn_debounce #(
   parameter int DEBOUNCE_BITS = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic press_pulse,
   output logic release_pulse
);

   logic [1:0]               sync;
   logic                     state;
   logic [DEBOUNCE_BITS-1:0] cnt;
   logic                     accept;

   // Accept once the input has differed for 2^DEBOUNCE_BITS consecutive clocks.
   assign accept        = (sync[1] != state) && (&cnt);
   assign press_pulse   = accept && sync[1];
   assign release_pulse = accept && !sync[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync  <= '0;
         state <= 1'b0;
         cnt   <= '0;
      end else begin
         sync <= {sync[0], btn};
         if ((sync[1] == state) || accept) cnt <= '0;
         else                              cnt <= cnt + 1;
         if (accept) state <= sync[1];
      end
   end

endmodule

// File: rtl/rgb_pwm_seq.sv
// N-channel triangle-fade LED sequencer with PWM outputs and run/pause/step control.
//
// state      | meaning
// RUN        | levels advance on every prescaler tick
// PAUSE      | levels frozen; a press steps once and enters PAUSE_HELD
// PAUSE_HELD | button held after a step; release -> PAUSE, long hold -> RUN
module rgb_pwm_seq
   import rgb_pwm_pkg::*;
#(
   parameter int CHANNELS      = 3,
   parameter int PWM_BITS      = 8,
   parameter int PRESCALE_BITS = 16,
   parameter int DEBOUNCE_BITS = 16,
   parameter int LONG_TICKS    = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   rgb_pwm_seq_if.slave  bus
);

   localparam int HOLD_W = $clog2(LONG_TICKS + 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_TICKS - 1);

   logic [1:0]                   rst_sync;
   logic                         rst_int_n;
   logic [PWM_BITS-1:0]          pwm_cnt;
   logic [PRESCALE_BITS-1:0]     presc;
   logic                         tick;
   logic                         press_pulse;
   logic                         release_pulse;
   mode_t                        mode, mode_nxt;
   logic [HOLD_W-1:0]            hold_cnt, hold_nxt;
   logic                         adv;
   logic                         adv_q;
   logic [CHANNELS-1:0]          pwm_q;
   logic [CHANNELS*PWM_BITS-1:0] lvl_all;
   logic [LVL_W-1:0]             max_ext;

   // Assertion is immediate; release is re-timed to clk.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync <= '0;
      else        rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_int_n = rst_sync[1];

   btn_debounce #(.DEBOUNCE_BITS(DEBOUNCE_BITS)) u_btn (
      .clk          (clk),
      .rst_n        (rst_int_n),
      .btn          (bus.btn),
      .press_pulse  (press_pulse),
      .release_pulse(release_pulse)
   );

   assign tick = &presc;

   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         pwm_cnt  <= '0;
         presc    <= '0;
         mode     <= RUN;
         hold_cnt <= '0;
         adv_q    <= 1'b0;
      end else begin
         pwm_cnt  <= pwm_cnt + 1;
         presc    <= presc + 1;
         mode     <= mode_nxt;
         hold_cnt <= hold_nxt;
         adv_q    <= adv;
      end
   end

   always_comb begin
      mode_nxt = mode;
      hold_nxt = hold_cnt;
      adv      = 1'b0;
      case (mode)
         RUN: begin
            adv = tick;
            if (press_pulse) mode_nxt = PAUSE;
         end
         PAUSE: begin
            if (press_pulse) begin
               mode_nxt = PAUSE_HELD;
               adv      = 1'b1;
               hold_nxt = '0;
            end
         end
         PAUSE_HELD: begin
            if (tick) hold_nxt = hold_cnt + 1;
            // A long hold beats a simultaneous release.
            if (tick && (hold_cnt == HOLD_LAST)) mode_nxt = RUN;
            else if (release_pulse)              mode_nxt = PAUSE;
         end
         default: mode_nxt = RUN;
      endcase
   end

   always_comb begin
      max_ext                = '0;
      max_ext[PWM_BITS-1:0]  = '1;
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      localparam logic [LVL_W-1:0] STEP = LVL_W'(c + 1);
      logic [PWM_BITS-1:0] lvl;
      logic                down;
      logic [LVL_W-1:0]    lvl_ext;
      logic [LVL_W:0]      nxt;

      always_comb begin
         lvl_ext                = '0;
         lvl_ext[PWM_BITS-1:0]  = lvl;
      end

      assign nxt = fade_step(lvl_ext, down, STEP, max_ext);

      always_ff @(posedge clk or negedge rst_int_n) begin
         if (!rst_int_n) begin
            lvl  <= '0;
            down <= 1'b0;
         end else if (adv) begin
            lvl  <= nxt[PWM_BITS-1:0];
            down <= nxt[LVL_W];
         end
      end

      assign lvl_all[c*PWM_BITS +: PWM_BITS] = lvl;
   end

   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         pwm_q <= '0;
      end else begin
         for (int c = 0; c < CHANNELS; c++)
            pwm_q[c] <= (pwm_cnt < lvl_all[c*PWM_BITS +: PWM_BITS]);
      end
   end

   assign bus.pwm_o     = pwm_q;
   assign bus.mode_o    = mode;
   assign bus.advance_o = adv_q;
   assign bus.lvl_o     = lvl_all;

endmodule

// File: tb/tb_rgb_pwm_seq.sv
// Directed bench for rgb_pwm_seq with a level scoreboard fed by a reference fade model.
module tb_rgb_pwm_seq;
   localparam int CH   = 3;
   localparam int PB   = 4;
   localparam int PS   = 4;
   localparam int DB   = 2;
   localparam int LT   = 3;
   localparam int MAXL = 15;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   rgb_pwm_seq_if #(.CHANNELS(CH), .PWM_BITS(PB)) bus ();

   rgb_pwm_seq #(
      .CHANNELS(CH), .PWM_BITS(PB), .PRESCALE_BITS(PS),
      .DEBOUNCE_BITS(DB), .LONG_TICKS(LT)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   logic [CH*PB-1:0] sb_q[$];
   int               m_lvl[CH];
   bit               m_down[CH];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   function automatic logic [CH*PB-1:0] model_vec();
      logic [CH*PB-1:0] v;
      v = '0;
      for (int c = 0; c < CH; c++) v[c*PB +: PB] = PB'(m_lvl[c]);
      return v;
   endfunction

   // Reference triangle fade: channel c moves by c+1, bouncing at 0 and MAXL.
   task automatic push_step();
      for (int c = 0; c < CH; c++) begin
         int s;
         s = c + 1;
         if (!m_down[c]) begin
            if (m_lvl[c] + s >= MAXL) begin
               m_lvl[c]  = MAXL;
               m_down[c] = 1'b1;
            end else begin
               m_lvl[c] = m_lvl[c] + s;
            end
         end else begin
            if (m_lvl[c] <= s) begin
               m_lvl[c]  = 0;
               m_down[c] = 1'b0;
            end else begin
               m_lvl[c] = m_lvl[c] - s;
            end
         end
      end
      sb_q.push_back(model_vec());
   endtask

   task automatic model_reset();
      for (int c = 0; c < CH; c++) begin
         m_lvl[c]  = 0;
         m_down[c] = 1'b0;
      end
   endtask

   always @(negedge clk) begin : mon
      logic [CH*PB-1:0] e;
      if (rst_n === 1'b1 && bus.advance_o === 1'b1) begin
         chk("advance_expected", 32'(sb_q.size() != 0), 32'd1);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("lvl_after_advance", 32'(bus.lvl_o), 32'(e));
         end
      end
   end

   task automatic wait_drain(input string tag, input int budget);
      int cyc;
      cyc = 0;
      while (sb_q.size() != 0 && cyc < budget) begin
         @(negedge clk); #1;
         cyc++;
      end
      chk(tag, 32'(sb_q.size()), 32'd0);
   endtask

   task automatic wait_mode(input string tag, input logic [1:0] exp, input int budget);
      int cyc;
      cyc = 0;
      while (bus.mode_o !== exp && cyc < budget) begin
         @(negedge clk); #1;
         cyc++;
      end
      chk(tag, 32'(bus.mode_o), 32'(exp));
   endtask

   int               cyc;
   int               hi[CH];
   int               adv_seen;
   bit               saw_held;
   logic [CH*PB-1:0] prev;

   initial begin
      bus.btn = 1'b0;
      model_reset();

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      chk("reset_mode", 32'(bus.mode_o), 32'd0);
      chk("reset_lvl", 32'(bus.lvl_o), 32'd0);
      chk("reset_pwm", 32'(bus.pwm_o), 32'd0);
      chk("reset_adv", 32'(bus.advance_o), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // 1/2: RUN fade, tick period and PWM duty per level
      for (int i = 0; i < 18; i++) begin
         prev = model_vec();
         push_step();
         cyc = 0;
         for (int c = 0; c < CH; c++) hi[c] = 0;
         while (sb_q.size() != 0 && cyc < 40) begin
            @(negedge clk); #1;
            cyc++;
            for (int c = 0; c < CH; c++) hi[c] += int'(bus.pwm_o[c]);
         end
         chk("fade_drain", 32'(sb_q.size()), 32'd0);
         if (i > 0) begin
            chk("tick_period", 32'(cyc), 32'd16);
            for (int c = 0; c < CH; c++)
               chk("pwm_duty", 32'(hi[c]), 32'(prev[c*PB +: PB]));
         end
      end

      // 3: glitches are rejected, each placed between ticks
      for (int g = 1; g <= 3; g++) begin
         push_step();
         wait_drain("glitch_tick", 24);
         bus.btn = 1'b1;
         repeat (g) @(negedge clk);
         bus.btn = 1'b0;
         repeat (6) @(negedge clk);
         #1;
         chk("glitch_mode", 32'(bus.mode_o), 32'd0);
      end
      push_step();
      wait_drain("pre_press_tick", 24);
      bus.btn = 1'b1;
      repeat (10) @(negedge clk);
      #1;
      chk("press_to_pause", 32'(bus.mode_o), 32'd1);
      bus.btn = 1'b0;
      repeat (60) @(negedge clk);
      #1;
      chk("pause_frozen", 32'(bus.lvl_o), 32'(model_vec()));
      chk("pause_mode", 32'(bus.mode_o), 32'd1);

      // 4: single step in PAUSE
      push_step();
      adv_seen = 0;
      saw_held = 1'b0;
      bus.btn  = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk); #1;
         adv_seen += int'(bus.advance_o);
         if (bus.mode_o === 2'd2) saw_held = 1'b1;
      end
      bus.btn = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk); #1;
         adv_seen += int'(bus.advance_o);
         if (bus.mode_o === 2'd2) saw_held = 1'b1;
      end
      chk("step_saw_held", 32'(saw_held), 32'd1);
      chk("step_back_pause", 32'(bus.mode_o), 32'd1);
      chk("step_one_pulse", 32'(adv_seen), 32'd1);
      chk("step_drained", 32'(sb_q.size()), 32'd0);

      // 5: long hold returns to RUN; later release ignored
      push_step();
      bus.btn = 1'b1;
      wait_mode("hold_enter", 2'd2, 12);
      wait_mode("long_hold_run", 2'd0, 80);
      chk("long_hold_drained", 32'(sb_q.size()), 32'd0);
      push_step();
      wait_drain("resume_tick", 24);
      bus.btn = 1'b0;
      repeat (10) @(negedge clk);
      #1;
      chk("release_in_run", 32'(bus.mode_o), 32'd0);
      push_step();
      wait_drain("resume_tick2", 24);

      // 6: reset during PAUSE_HELD
      bus.btn = 1'b1;
      repeat (8) @(negedge clk);
      #1;
      chk("pause_again", 32'(bus.mode_o), 32'd1);
      bus.btn = 1'b0;
      repeat (10) @(negedge clk);
      push_step();
      bus.btn = 1'b1;
      wait_mode("held_again", 2'd2, 12);
      repeat (2) @(negedge clk);
      #1;
      chk("held_lvl", 32'(bus.lvl_o), 32'(model_vec()));
      rst_n = 1'b0;
      #1;
      chk("rst_pwm", 32'(bus.pwm_o), 32'd0);
      chk("rst_lvl", 32'(bus.lvl_o), 32'd0);
      chk("rst_adv", 32'(bus.advance_o), 32'd0);
      chk("rst_mode", 32'(bus.mode_o), 32'd0);
      model_reset();
      bus.btn = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_hold_lvl", 32'(bus.lvl_o), 32'd0);
      chk("rst_queue", 32'(sb_q.size()), 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         push_step();
         wait_drain("restart_tick", 40);
      end
      chk("restart_mode", 32'(bus.mode_o), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/rgb_pwm_seq.md
# rgb_pwm_seq

Parametrised RGB/N-channel LED sequencer for the pico-ice iCE40 designs. Each channel runs a triangle fade at its own rate, and its level drives an N-bit PWM comparator. A debounced push-button selects run, pause or single-step mode. The block sits between the board clock/button pins and the SB_RGBA_DRV PWM inputs (`pwm_o[c]` → `RGBnPWM`), replacing ad-hoc counter-bit colour blinking.

## Interface
Parameters:
- `CHANNELS`, 3: number of LED channels (1–8).
- `PWM_BITS`, 8: PWM counter and level width; MAX = 2^PWM_BITS−1.
- `PRESCALE_BITS`, 16: fade tick period = 2^PRESCALE_BITS clocks.
- `DEBOUNCE_BITS`, 16: button must differ from the debounced state for 2^DEBOUNCE_BITS consecutive clocks before the change is accepted.
- `LONG_TICKS`, 32: hold length, in fade ticks, that leaves pause mode.

Ports:
- `clk` in 1: single clock (ICE_CLK domain).
- `rst_n` in 1: reset, asynchronous, active-low.
- `btn` in 1: raw button, asynchronous, active-high = pressed.
- `pwm_o` out CHANNELS: per-channel PWM, registered.
- `mode_o` out 2: 0 = RUN, 1 = PAUSE, 2 = PAUSE_HELD.
- `advance_o` out 1: one-cycle pulse when levels advance.
- `lvl_o` out CHANNELS*PWM_BITS: current levels; channel c is at bits [c*PWM_BITS +: PWM_BITS].

## Operation
- Reset values: all counters 0; `lvl[c]` = 0; `dir[c]` = up; mode RUN; `pwm_o` = 0; `advance_o` = 0; synchroniser and debounced state = 0.
- PWM: `pwm_cnt` (PWM_BITS wide) runs freely and wraps MAX→0. `pwm_o[c]` ← (`pwm_cnt` < `lvl[c]`).
  - lvl 0 → never high.
  - lvl MAX → high MAX of every 2^PWM_BITS cycles.
- Prescaler: `tick` asserts for one cycle when the prescaler counter equals all-ones, then the counter wraps.
- Advance (`adv`):
  - In RUN: `adv` = `tick`.
  - In PAUSE/PAUSE_HELD: `adv` = step event only; ticks are ignored.
  - On `adv`, channel c uses step s = c+1:
    - Up: if `lvl` + s ≥ MAX, then `lvl` = MAX and `dir` = down; else `lvl` += s.
    - Down: if `lvl` ≤ s, then `lvl` = 0 and `dir` = up; else `lvl` −= s.
    - Compute the sum one bit wider; no wrap-around.
- Button path:
  - 2-flop synchroniser.
  - Debouncer counter clears whenever the synchronised value equals the debounced state; otherwise it increments. On the cycle it reaches all-ones, the debounced state takes the synchronised value and the counter clears.
  - `press` = one-cycle pulse on a debounced rising edge; `release` = one-cycle pulse on a falling edge.
- FSM:
  - RUN → PAUSE on `press`.
  - PAUSE → PAUSE_HELD on `press`; the same cycle is a step event (`adv`) and clears `hold_cnt`.
  - PAUSE_HELD → PAUSE on `release`.
  - PAUSE_HELD → RUN when `hold_cnt` reaches LONG_TICKS. `hold_cnt` counts ticks while in PAUSE_HELD.
  - `release` in RUN or PAUSE is ignored. After a long hold the mode is RUN, so the eventual release is ignored.
  - If `release` and the LONG_TICKS threshold occur in the same cycle, the threshold wins and the next mode is RUN.
- `advance_o` is `adv` registered.

## Timing
- `pwm_o`: 1 cycle after the `pwm_cnt`/`lvl` values it compares.
- `lvl`/`dir`: update on the edge where `adv` = 1, visible the next cycle. `advance_o` rises on that same edge.
- Button: a clean edge on `btn` produces `press` after 2 (sync) + 2^DEBOUNCE_BITS cycles. The mode changes on the following edge.
- Step latency: `press` → `lvl_o` updated in 1 cycle.
- `rst_n` low at any time, including mid-debounce or mid-hold: all state returns to reset values immediately. Release of `rst_n` is synchronised by the top level.

## Structure
- Package `rgb_pwm_pkg`:
  - `mode_t` enum (RUN = 0, PAUSE = 1, PAUSE_HELD = 2).
  - Helper function for the saturating up/down step.
- Sub-module `btn_debounce`: synchroniser, debouncer, `press`/`release` pulses; parameter DEBOUNCE_BITS.
- The top module contains the PWM counter, prescaler, FSM and the per-channel level generate loop.

## Test plan
Parameters: CHANNELS=3, PWM_BITS=4, PRESCALE_BITS=4, DEBOUNCE_BITS=2, LONG_TICKS=3.
1. Fade, RUN mode from reset → ticks every 16 cycles.
   - ch0 `lvl`: 1, 2, …, 15, then 14 (dir down).
   - ch2 `lvl`: 3, 6, 9, 12, 15, 12, …, 3, 0, 3.
2. Force `lvl` to 5/0/15 → `pwm_o` high for 5/0/15 cycles of each 16.
3. `btn` glitches of 1–3 cycles → `mode_o` stays 0. Clean press held 10 cycles → `mode_o` = 1 and `lvl_o` frozen across ≥3 ticks.
4. In PAUSE, press held 8 cycles then released → exactly one `advance_o` pulse, ch0 `lvl` +1, `mode_o` 1→2→1.
5. In PAUSE, hold ≥3 ticks → `mode_o` = 0 and fading resumes; later release → still 0.
6. `rst_n` pulsed low during PAUSE_HELD with levels nonzero → `pwm_o`, `lvl_o`, `advance_o` = 0 and `mode_o` = 0 while low; after release the fade restarts from 0.
